// File: rtl/pm_pkg.sv
// Shared widths, reset constants and the path-metric record layout for the PM stage FIFO.
// pm_rec_t uses the default widths; the field order matches the FIFO's head outputs.
package pm_pkg;

   localparam int PM_W_DEF   = 7;
   localparam int ADDR_W_DEF = 2;
   localparam int ID_W_DEF   = 3;

   localparam logic TERM_RST = 1'b1;

   typedef struct packed {
      logic [PM_W_DEF-1:0]   pm;
      logic [ADDR_W_DEF-1:0] addr;
      logic                  dec;
      logic                  term;
      logic [ID_W_DEF-1:0]   id;
      logic                  norm;
   } pm_rec_t;

endpackage

// File: rtl/pm_fifo_ctrl.sv
// Pointer/occupancy control for the PM stage FIFO: push/pop strobes, flush, next-head index.
// in_ready depends on count only and is held low until the first clock after reset.
module pm_fifo_ctrl #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic                     out_ready,
   output logic                     in_ready,
   output logic                     empty,
   output logic                     push,
   output logic                     pop,
   output logic                     valid_nxt,
   output logic [$clog2(DEPTH)-1:0] wptr,
   output logic [$clog2(DEPTH)-1:0] rptr_nxt,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic          live;
   logic          full;
   logic [PW-1:0] rptr;
   logic [CW-1:0] count_nxt;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign in_ready = live & ~full;

   // A flushed cycle neither stores nor retires anything.
   assign push = in_valid & in_ready & ~flush;
   assign pop  = out_ready & ~empty & ~flush;

   assign rptr_nxt  = rptr + PW'(pop);
   assign count_nxt = count + CW'(push) - CW'(pop);
   assign valid_nxt = ~flush & (count_nxt != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         live  <= 1'b0;
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         live <= 1'b1;
         if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
         end else begin
            if (push) begin
               wptr <= wptr + PW'(1);
            end
            rptr  <= rptr_nxt;
            count <= count_nxt;
         end
      end
   end

endmodule

// File: rtl/pm_stage_fifo.sv
// Path-metric record FIFO between ACS and traceback; registered head, 1-cycle fill latency, outputs hold while stalled.
// in_ready = !full with no out_ready path. Optional metric normalisation under PM_NORM_EN.
module pm_stage_fifo
   import pm_pkg::*;
#(
   parameter int PM_W   = PM_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int ID_W   = ID_W_DEF,
   parameter int DEPTH  = 4
) (
   input  logic                     PM_clk,
   input  logic                     PM_rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [PM_W-1:0]          PM_in,
   input  logic [ADDR_W-1:0]        addr_in,
   input  logic                     dec_in,
   input  logic                     term_in,
   input  logic [ID_W-1:0]          data_id,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PM_W-1:0]          PM_out,
   output logic [ADDR_W-1:0]        addr_out,
   output logic                     dec_out,
   output logic                     term_out,
   output logic [ID_W-1:0]          data_id_out,
   output logic                     norm_out,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [PM_W-1:0]   pm;
      logic [ADDR_W-1:0] addr;
      logic              dec;
      logic              term;
      logic [ID_W-1:0]   id;
   } ent_t;

   ent_t          mem [DEPTH];
   ent_t          wr_ent;
   ent_t          head_ent;
   logic          push;
   logic          pop;
   logic          empty;
   logic          valid_nxt;
   logic          head_bypass;
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr_nxt;

   pm_fifo_ctrl #(
      .DEPTH(DEPTH)
   ) u_ctrl (
      .clk       (PM_clk),
      .rst       (PM_rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .out_ready (out_ready),
      .in_ready  (in_ready),
      .empty     (empty),
      .push      (push),
      .pop       (pop),
      .valid_nxt (valid_nxt),
      .wptr      (wptr),
      .rptr_nxt  (rptr_nxt),
      .count     (count)
   );

   always_comb begin
      wr_ent = '{pm: PM_in, addr: addr_in, dec: dec_in, term: term_in, id: data_id};
`ifdef PM_NORM_EN
      wr_ent.pm[PM_W-1] = 1'b0;
`endif
   end

   always_ff @(posedge PM_clk) begin
      if (push) begin
         mem[wptr] <= wr_ent;
      end
   end

   // When nothing older survives this edge, the record being written becomes the head directly.
   assign head_bypass = empty | (pop & (count == CW'(1)));
   assign head_ent    = head_bypass ? wr_ent : mem[rptr_nxt];

   always_ff @(posedge PM_clk or posedge PM_rst) begin
      if (PM_rst) begin
         out_valid   <= 1'b0;
         PM_out      <= '0;
         addr_out    <= '0;
         dec_out     <= 1'b0;
         term_out    <= TERM_RST;
         data_id_out <= '0;
      end else if (flush) begin
         out_valid   <= 1'b0;
         PM_out      <= '0;
         addr_out    <= '0;
         dec_out     <= 1'b0;
         term_out    <= TERM_RST;
         data_id_out <= '0;
      end else begin
         out_valid <= valid_nxt;
         if (valid_nxt) begin
            PM_out      <= head_ent.pm;
            addr_out    <= head_ent.addr;
            dec_out     <= head_ent.dec;
            term_out    <= head_ent.term;
            data_id_out <= head_ent.id;
         end
      end
   end

`ifdef PM_NORM_EN
   logic norm_mem [DEPTH];
   logic wr_norm;

   assign wr_norm = PM_in[PM_W-1];

   always_ff @(posedge PM_clk) begin
      if (push) begin
         norm_mem[wptr] <= wr_norm;
      end
   end

   always_ff @(posedge PM_clk or posedge PM_rst) begin
      if (PM_rst) begin
         norm_out <= 1'b0;
      end else if (flush) begin
         norm_out <= 1'b0;
      end else if (valid_nxt) begin
         norm_out <= head_bypass ? wr_norm : norm_mem[rptr_nxt];
      end
   end
`else
   assign norm_out = 1'b0;
`endif

endmodule

// File: tb/tb_pm_stage_fifo.sv
// Bench for pm_stage_fifo: randomized traffic against a queue-based record model.
module tb_pm_stage_fifo;
   import pm_pkg::*;

   localparam int DEPTH = 4;
   localparam pm_rec_t RST_REC = '{pm: 7'd0, addr: 2'd0, dec: 1'b0, term: 1'b1, id: 3'd0, norm: 1'b0};

   logic       PM_clk = 1'b0;
   logic       PM_rst = 1'b0;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [6:0] PM_in = '0;
   logic [1:0] addr_in = '0;
   logic       dec_in = 1'b0;
   logic       term_in = 1'b0;
   logic [2:0] data_id = '0;
   logic       in_ready, out_valid, dec_out, term_out, norm_out;
   logic [6:0] PM_out;
   logic [1:0] addr_out;
   logic [2:0] data_id_out;
   logic [2:0] count;

   pm_rec_t obs;
   pm_rec_t mq[$];
   pm_rec_t exp_last = '{pm: 7'd0, addr: 2'd0, dec: 1'b0, term: 1'b1, id: 3'd0, norm: 1'b0};
   int      checks = 0;
   int      errors = 0;

   always #5 PM_clk = ~PM_clk;

   pm_stage_fifo #(
      .PM_W(PM_W_DEF), .ADDR_W(ADDR_W_DEF), .ID_W(ID_W_DEF), .DEPTH(DEPTH)
   ) dut (
      .PM_clk(PM_clk), .PM_rst(PM_rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .PM_in(PM_in), .addr_in(addr_in), .dec_in(dec_in), .term_in(term_in), .data_id(data_id),
      .out_valid(out_valid), .out_ready(out_ready),
      .PM_out(PM_out), .addr_out(addr_out), .dec_out(dec_out), .term_out(term_out),
      .data_id_out(data_id_out), .norm_out(norm_out), .count(count)
   );

   assign obs = {PM_out, addr_out, dec_out, term_out, data_id_out, norm_out};

   // Record as it should be stored, from the current inputs.
   function automatic pm_rec_t model_rec();
      pm_rec_t r;
      r.pm = PM_in; r.addr = addr_in; r.dec = dec_in; r.term = term_in; r.id = data_id; r.norm = 1'b0;
`ifdef PM_NORM_EN
      if (PM_in >= 7'd64) begin
         r.pm = PM_in - 7'd64;
         r.norm = 1'b1;
      end
`endif
      return r;
   endfunction

   task automatic set_in(input logic v, input logic [6:0] pm, input logic [1:0] a,
                         input logic d, input logic t, input logic [2:0] id);
      in_valid = v; PM_in = pm; addr_in = a; dec_in = d; term_in = t; data_id = id;
   endtask

   // One clock: update the model from the inputs presented at the edge, then settle.
   task automatic cyc();
      bit do_push, do_pop;
      do_push = in_valid && !flush && (mq.size() < DEPTH);
      do_pop  = out_ready && !flush && (mq.size() != 0);
      @(posedge PM_clk);
      if (flush) mq.delete();
      else begin
         if (do_pop) void'(mq.pop_front());
         if (do_push) mq.push_back(model_rec());
      end
      if (flush) exp_last = RST_REC;
      else if (mq.size() != 0) exp_last = mq[0];
      #1;
   endtask

   task automatic test_reset();
      #2 PM_rst = 1'b1;
      #1;
      checks++; if ({out_valid, in_ready, count} !== 5'b0) begin errors++;
         $display("FAIL reset_flags: got v=%b r=%b c=%0d need 0,0,0", out_valid, in_ready, count); end
      checks++; if (obs !== RST_REC) begin errors++;
         $display("FAIL reset_data: got %h need %h", obs, RST_REC); end
      @(negedge PM_clk) PM_rst = 1'b0;
      repeat (2) @(posedge PM_clk);
      #1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
         $display("FAIL reset_release: got r=%b v=%b need r=1 v=0", in_ready, out_valid); end
      // Load two records, then hit reset mid-cycle.
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         set_in(1'b1, 7'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 3'(i));
         cyc();
      end
      in_valid = 1'b0;
      checks++; if (count !== 3'd2) begin errors++;
         $display("FAIL reset_preload: got count %0d need 2", count); end
      @(posedge PM_clk);
      #3 PM_rst = 1'b1;
      #1;
      mq.delete();
      exp_last = RST_REC;
      checks++; if ({out_valid, in_ready, count} !== 5'b0 || obs !== RST_REC) begin errors++;
         $display("FAIL reset_async: got v=%b r=%b c=%0d d=%h need 0,0,0,%h", out_valid, in_ready, count, obs, RST_REC); end
      @(negedge PM_clk) PM_rst = 1'b0;
      repeat (2) @(posedge PM_clk);
      #1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || obs !== RST_REC) begin errors++;
         $display("FAIL reset_after: got r=%b v=%b d=%h need 1,0,%h", in_ready, out_valid, obs, RST_REC); end
   endtask

   task automatic test_single();
      pm_rec_t held;
      out_ready = 1'b0;
      set_in(1'b1, 7'h15, 2'd2, 1'b1, 1'b0, 3'd5);
      cyc();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || count !== 3'd1) begin errors++;
         $display("FAIL single_valid: got v=%b c=%0d need 1,1", out_valid, count); end
      checks++; if (obs !== '{pm: 7'h15, addr: 2'd2, dec: 1'b1, term: 1'b0, id: 3'd5, norm: 1'b0}) begin errors++;
         $display("FAIL single_data: got %h", obs); end
      held = obs;
      for (int i = 0; i < 3; i++) begin
         cyc();
         checks++; if (obs !== held || out_valid !== 1'b1) begin errors++;
            $display("FAIL single_stall%0d: got %h v=%b need %h v=1", i, obs, out_valid, held); end
      end
      out_ready = 1'b1;
      cyc();
      checks++; if (out_valid !== 1'b0 || count !== 3'd0 || obs !== exp_last) begin errors++;
         $display("FAIL single_drain: got v=%b c=%0d d=%h need 0,0,%h", out_valid, count, obs, exp_last); end
      cyc();
      checks++; if (out_valid !== 1'b0 || obs !== exp_last) begin errors++;
         $display("FAIL empty_hold: got v=%b d=%h need 0,%h", out_valid, obs, exp_last); end
   endtask

   task automatic test_fill_drain();
      int  got[$];
      bit  took;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_in(1'b1, 7'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 3'(i));
         checks++; if (in_ready !== (i < DEPTH)) begin errors++;
            $display("FAIL fill_ready%0d: got %b need %b", i, in_ready, i < DEPTH); end
         cyc();
      end
      checks++; if (count !== 3'(DEPTH) || in_ready !== 1'b0) begin errors++;
         $display("FAIL fill_full: got c=%0d r=%b need %0d,0", count, in_ready, DEPTH); end
      out_ready = 1'b1;
      for (int c = 0; c < 12 && got.size() < 5; c++) begin
         if (out_valid) got.push_back(int'(data_id_out));
         took = in_valid && in_ready;
         cyc();
         if (took) in_valid = 1'b0;
         if (c == 0) begin
            checks++; if (in_ready !== 1'b1) begin errors++;
               $display("FAIL full_pop_ready: got %b need 1", in_ready); end
         end
         checks++; if (obs !== exp_last || count !== 3'(mq.size())) begin errors++;
            $display("FAIL drain_head%0d: got %h c=%0d need %h c=%0d", c, obs, count, exp_last, mq.size()); end
      end
      in_valid = 1'b0;
      checks++; if (got.size() != 5) begin errors++;
         $display("FAIL drain_count: got %0d records need 5", got.size()); end
      for (int k = 0; k < got.size(); k++) begin
         checks++; if (got[k] != k) begin errors++;
            $display("FAIL drain_order%0d: got id %0d need %0d", k, got[k], k); end
      end
   endtask

   task automatic test_back_to_back();
      int pops = 0;
      out_ready = 1'b0;
      set_in(1'b1, 7'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 3'd0);
      cyc();
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         set_in(1'b1, 7'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 3'(i + 1));
         if (out_valid) pops++;
         cyc();
         checks++; if (count !== 3'd1 || out_valid !== 1'b1 || obs !== exp_last) begin errors++;
            $display("FAIL b2b%0d: got c=%0d v=%b d=%h need 1,1,%h", i, count, out_valid, obs, exp_last); end
      end
      in_valid = 1'b0;
      checks++; if (pops != 16) begin errors++;
         $display("FAIL b2b_rate: got %0d pops need 16", pops); end
      cyc();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 7'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 3'(i + 1));
         cyc();
      end
      checks++; if (count !== 3'd3) begin errors++;
         $display("FAIL flush_pre: got count %0d need 3", count); end
      set_in(1'b1, 7'h33, 2'd1, 1'b1, 1'b0, 3'd7);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      in_valid = 1'b0;
      checks++; if (count !== 3'd0 || out_valid !== 1'b0 || obs !== RST_REC) begin errors++;
         $display("FAIL flush_clear: got c=%0d v=%b d=%h need 0,0,%h", count, out_valid, obs, RST_REC); end
      repeat (2) cyc();
      checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++;
         $display("FAIL flush_dropped: got v=%b c=%0d need 0,0", out_valid, count); end
   endtask

   task automatic test_norm();
      logic [6:0] exp_pm;
      logic       exp_n;
      out_ready = 1'b0;
      set_in(1'b1, 7'h50, 2'd1, 1'b0, 1'b1, 3'd2);
      cyc();
      in_valid = 1'b0;
`ifdef PM_NORM_EN
      exp_pm = 7'h10; exp_n = 1'b1;
`else
      exp_pm = 7'h50; exp_n = 1'b0;
`endif
      checks++; if (PM_out !== exp_pm || norm_out !== exp_n) begin errors++;
         $display("FAIL norm_hi: got pm=%h n=%b need %h,%b", PM_out, norm_out, exp_pm, exp_n); end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      set_in(1'b1, 7'h2A, 2'd3, 1'b1, 1'b0, 3'd3);
      cyc();
      in_valid = 1'b0;
      checks++; if (PM_out !== 7'h2A || norm_out !== 1'b0 || obs !== exp_last) begin errors++;
         $display("FAIL norm_lo: got %h need pm=2a n=0 (%h)", obs, exp_last); end
      out_ready = 1'b1;
      cyc();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         flush = ($urandom_range(0, 31) == 0);
         set_in(1'($urandom), 7'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
         out_ready = ($urandom_range(0, 2) != 0);
         checks++; if (in_ready !== (mq.size() < DEPTH)) begin errors++;
            $display("FAIL rnd_ready%0d: got %b need %b", i, in_ready, mq.size() < DEPTH); end
         cyc();
         checks++; if (count !== 3'(mq.size()) || out_valid !== (mq.size() != 0) || obs !== exp_last) begin errors++;
            $display("FAIL rnd%0d: got c=%0d v=%b d=%h need c=%0d v=%b d=%h",
                     i, count, out_valid, obs, mq.size(), mq.size() != 0, exp_last); end
      end
      flush = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded its time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_fill_drain();
      test_back_to_back();
      test_flush();
      test_norm();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pm_stage_fifo.md
Name: pm_stage_fifo

Overview:
- Parametrised successor to the single-register path-metric pipeline stage in the pipelined Viterbi decoder.
- Buffers path-metric records between add-compare-select (ACS) stages and the traceback/decision logic.
- A record is {PM, addr, dec, term, data_id}. The block holds up to DEPTH records behind a valid/ready handshake.
- Adds an occupancy count, a synchronous flush, and optional metric normalisation.

Parameters:
- PM_W, 7: path-metric width in bits.
- ADDR_W, 2: state-address width.
- ID_W, 3: data_id width.
- DEPTH, 4: number of buffered records; power of two, ≥2.

Ports:
- PM_clk  in  1  clock; all logic on the rising edge.
- PM_rst  in  1  reset; asynchronous, active-high.
- flush  in  1  synchronous clear of all buffered records.
- in_valid  in  1  upstream record valid.
- in_ready  out  1  block can accept a record.
- PM_in  in  PM_W  path metric.
- addr_in  in  ADDR_W  state address.
- dec_in  in  1  ACS decision bit.
- term_in  in  1  termination flag.
- data_id  in  ID_W  record tag.
- out_valid  out  1  head record valid.
- out_ready  in  1  downstream accepts the head record.
- PM_out  out  PM_W  head path metric.
- addr_out  out  ADDR_W  head address.
- dec_out  out  1  head decision bit.
- term_out  out  1  head termination flag.
- data_id_out  out  ID_W  head tag.
- norm_out  out  1  head metric was normalised.
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset (asynchronous, active-high):
  - count=0, out_valid=0, in_ready=0.
  - PM_out=0, addr_out=0, dec_out=0, data_id_out=0, norm_out=0.
  - term_out=1.
  - Pointers are cleared.
  - Reset mid-transfer discards all records, with no partial output.
- After reset deasserts: in_ready=!full, combinational from count only; it has no path from out_ready.
- Push:
  - Occurs when in_valid && in_ready at the clock edge.
  - The record is written at the write pointer; wptr increments, wrapping modulo DEPTH.
- Pop:
  - Occurs when out_valid && out_ready at the clock edge.
  - rptr increments, wrapping modulo DEPTH.
- Output registers:
  - Outputs are registered copies of the head entry.
  - out_valid = (count≠0) is a registered flag.
  - Latency from push into an empty buffer to out_valid=1 is exactly 1 cycle.
- Simultaneous push and pop: count is unchanged and the head advances.
  - When count=1, the new record appears on the outputs the next cycle.
- Boundary conditions:
  - Full (count=DEPTH): in_ready=0, so a push is impossible. A pop in that cycle raises in_ready on the next cycle.
  - Empty: out_ready is ignored. Data outputs hold their last value; term_out holds too, and is 1 after reset.
- Stability: while out_valid && !out_ready, all outputs hold stable.
- Flush:
  - Takes effect next cycle: count=0, out_valid=0, pointers cleared, data outputs set to their reset values.
  - A push in the same cycle as flush is dropped.
  - Flush has priority over push and pop.
- Width rules:
  - count never exceeds DEPTH.
  - PM is stored unmodified unless PM_NORM_EN is defined.

Optional Feature:
- Macro: PM_NORM_EN.
- With PM_NORM_EN defined:
  - On push, if PM_in[PM_W-1]=1, the stored metric is PM_in with the MSB cleared (PM_in − 2^(PM_W-1)), and a per-entry norm bit is stored as 1. Otherwise norm=0.
  - norm_out presents the head entry's norm bit.
- Without PM_NORM_EN:
  - PM is passed through unchanged.
  - norm_out is tied to 0 and no per-entry norm storage is built.

Decomposition:
- Shared package pm_pkg:
  - Default widths PM_W_DEF=7, ADDR_W_DEF=2, ID_W_DEF=3.
  - Reset constant TERM_RST=1'b1.
  - Packed record typedef pm_rec_t {pm, addr, dec, term, id, norm}.
- One sub-module, pm_fifo_ctrl:
  - Holds wptr, rptr and count, including the flush logic.
  - Produces the full, empty, push and pop strobes.
- The storage array and output registers stay in pm_stage_fifo.

Test Plan:
- Reset, then idle:
  - Assert PM_rst mid-cycle → outputs go immediately to PM_out=0, term_out=1, out_valid=0, count=0.
  - After release → in_ready=1.
- Single record:
  - Push {PM=0x15, addr=2, dec=1, term=0, id=5} with out_ready=0 → next cycle out_valid=1 and outputs equal the record; count=1.
  - Outputs hold for 3 stalled cycles.
- Fill and drain with DEPTH=4:
  - Push ids 0..4 back-to-back with out_ready=0 → ids 0..3 accepted, in_ready=0 at count=4, id 4 held off.
  - Then out_ready=1 → ids emerge 0,1,2,3,4 in order, with no duplicates or drops.
- Simultaneous push/pop: stream 16 records with in_valid=out_ready=1 continuously → count stays 1 and throughput is 1 record/cycle.
- Flush: with count=3, assert flush together with in_valid → next cycle count=0, out_valid=0, term_out=1, and the flushed push is absent.
- PM_NORM_EN, PM_W=7:
  - Push PM_in=0x50 → PM_out=0x10, norm_out=1.
  - Push PM_in=0x2A → PM_out=0x2A, norm_out=0.
  - Build without the macro → PM_out=0x50, norm_out=0.
